// File: rtl/serial_add_arb.sv
// Two-requester arbiter sharing one bit-serial (LSB-first) adder.
// Round-robin grant in IDLE, WIDTH shift cycles, result held in DONE.
module serial_add_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             id;
    logic             last_gnt;

    logic             idle;
    logic             pick1;
    logic             s;
    logic             c_n;

    // last_gnt=1 means requester 1 won last, so requester 0 wins a tie
    always_comb begin
        idle       = (state == IDLE) && !rst;
        pick1      = req1_valid && (!req0_valid || !last_gnt);
        req1_ready = idle && pick1;
        req0_ready = idle && req0_valid && !pick1;
    end

    always_comb begin
        s   = a_sr[0] ^ b_sr[0] ^ carry;
        c_n = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            id        <= 1'b0;
            last_gnt  <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_sr     <= pick1 ? req1_a : req0_a;
                        b_sr     <= pick1 ? req1_b : req0_b;
                        carry    <= 1'b0;
                        cnt      <= '0;
                        id       <= pick1;
                        last_gnt <= pick1;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= c_n;
                    sum_sr <= {s, sum_sr[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_sum  = sum_sr;
    assign rsp_cout = carry;
    assign rsp_id   = id;

endmodule

// File: tb/tb_serial_add_arb.sv
// Scoreboard bench for serial_add_arb: directed cases plus random traffic.
// Expected sums come from plain a+b; grants from a round-robin model.
module tb_serial_add_arb;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout, rsp_id, busy;

    serial_add_arb #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         id;
        logic         cout;
        logic [W-1:0] sum;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   gcyc = 0;
    int   n_acc = 0;
    logic last_m = 1'b1;
    bit   outst = 0;
    logic pv = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: grants pushed from the model, responses popped and compared
    always @(negedge clk) begin
        logic         exp_id;
        logic [W:0]   s9;
        logic [W-1:0] a, b;
        if (rst) begin
            chk("ready_in_rst", {req0_ready, req1_ready}, 0);
            q.delete();
            outst  = 0;
            last_m = 1'b1;
            pv     = 1'b0;
        end else begin
            chk("busy", busy, outst);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", q.size(), 1);
                end else begin
                    chk("rsp_sum", rsp_sum, q[0].sum);
                    chk("rsp_cout", rsp_cout, q[0].cout);
                    chk("rsp_id", rsp_id, q[0].id);
                    if (!pv) chk("latency", cyc - gcyc, W + 1);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        outst = 0;
                    end
                end
            end
            if (req0_ready || req1_ready) begin
                chk("ready_while_busy", outst, 0);
                chk("two_ready", req0_ready & req1_ready, 0);
                exp_id = (req0_valid && req1_valid) ? !last_m : req1_valid;
                chk("grant_id", req1_ready, exp_id);
                chk("ready_wo_valid", req1_ready ? req1_valid : req0_valid, 1);
                a  = exp_id ? req1_a : req0_a;
                b  = exp_id ? req1_b : req0_b;
                s9 = {1'b0, a} + {1'b0, b};
                q.push_back('{id: exp_id, cout: s9[W], sum: s9[W-1:0]});
                last_m = exp_id;
                outst  = 1;
                gcyc   = cyc;
                n_acc++;
            end
            pv = rsp_valid;
        end
    end

    task automatic issue(bit id, logic [W-1:0] a, logic [W-1:0] b);
        int n = 0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_ready : req0_ready) && n < 200);
        if (n >= 200) chk("issue_timeout", n, 0);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_cout", rsp_cout, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // both valid from reset: grants must alternate starting with 0
        start = n_acc;
        n = 0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        while (n_acc < start + 8 && n < 400) begin
            req0_a = W'($urandom); req0_b = W'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) chk("alt_timeout", n_acc - start, 8);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        issue(0, 8'h0F, 8'h01);
        wait_idle();
        issue(1, 8'hFF, 8'h01);
        wait_idle();
        issue(1, 8'hFF, 8'hFF);
        wait_idle();
        issue(0, 8'h00, 8'h00);
        wait_idle();

        // stall in DONE with the other requester knocking
        rsp_ready = 1'b0;
        issue(0, 8'h3C, 8'h55);
        req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_done", rsp_valid, 1);
        repeat (20) @(negedge clk);
        chk("stall_valid", rsp_valid, 1);
        chk("stall_busy", busy, 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_valid", rsp_valid, 0);
        chk("release_busy", busy, 0);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_idle();

        // reset during the 4th shift cycle aborts the add
        issue(1, 8'hF0, 8'hF0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk);
        #1;
        issue(1, 8'h7F, 8'h01);
        wait_idle();

        // random traffic
        start = n_acc;
        n = 0;
        while (n_acc < start + 1000 && n < 60000) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
            req0_b = W'($urandom);
            req1_a = W'($urandom);
            req1_b = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 60000) chk("random_timeout", n_acc - start, 1000);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        chk("lost_rsp", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
